mem_requester: RTL and testbench

MEM_REQUESTER -- requirements
Module: mem_requester

---
 rtl/mem_requester_pkg.sv | 19 +
 rtl/req_fifo2.sv | 52 +++++
 rtl/mem_requester.sv | 125 ++++++++++++
 tb/tb_mem_requester.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_requester_pkg.sv
// Shared memory-subsystem definitions: requester FSM encoding, grant-timeout defaults and
// the stall-counter helper.
package mem_requester_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StReq    = 2'd1,
        StRdWait = 2'd2,
        StResp   = 2'd3
    } mem_state_e;

    localparam int unsigned MemTmoDefault = 16;
    localparam int unsigned StallCntW     = 5;

    function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] v);
        return (v == '1) ? v : v + StallCntW'(1);
    endfunction

endpackage

// File: rtl/req_fifo2.sv
// Two-entry command FIFO; flags come straight from registered state so that the
// ready signal never depends on a same-cycle pop.
module req_fifo2 #(
    parameter int unsigned Width = 17
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             push_ok, pop_ok;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign data_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_ok;
        rd_ptr_d = rd_ptr_q ^ pop_ok;
        cnt_d    = cnt_q + {1'b0, push_ok} - {1'b0, pop_ok};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Core-side memory requester: queues load/store commands and issues them one at a time
// to a memory-controller requester slot, reporting completion and grant timeouts.
module mem_requester
    import mem_requester_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TMO    = MemTmoDefault
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_we,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mc_rden,
    output logic              mc_wren,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [DATA_W-1:0] mc_din,
    input  logic              mc_acq,
    input  logic [DATA_W-1:0] mc_dq,
    output logic              busy,
    output logic              stall_err
);

    localparam int unsigned          EntW   = 1 + ADDR_W + DATA_W;
    localparam logic [StallCntW-1:0] TmoCnt = StallCntW'(TMO);

    mem_state_e             state_q, state_d;
    logic [StallCntW-1:0]   cnt_q, cnt_d;
    logic                   stall_q, stall_d;
    logic                   rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;

    logic                   fifo_full, fifo_empty, fifo_pop;
    logic [EntW-1:0]        fifo_dout;
    logic                   head_we;
    logic [ADDR_W-1:0]      head_addr;
    logic [DATA_W-1:0]      head_wdata;
    logic                   in_req;

    req_fifo2 #(
        .Width (EntW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cmd_valid & cmd_ready),
        .data_i  ({cmd_we, cmd_addr, cmd_wdata}),
        .pop_i   (fifo_pop),
        .data_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {head_we, head_addr, head_wdata} = fifo_dout;

    // Request lines are pure decodes of the state register, so reset drops them at once.
    assign in_req    = (state_q == StReq);
    assign mc_rden   = in_req & ~head_we;
    assign mc_wren   = in_req & head_we;
    assign mc_addr   = in_req ? head_addr : '0;
    assign mc_din    = in_req ? head_wdata : '0;

    assign cmd_ready = ~fifo_full;
    assign rsp_valid = (state_q == StResp);
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rdata_q;
    assign busy      = (state_q != StIdle) | ~fifo_empty;
    assign stall_err = stall_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stall_d  = stall_q;
        rsp_we_d = rsp_we_q;
        rdata_d  = rdata_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) state_d = StReq;
            end
            StReq: begin
                if (mc_acq) begin
                    fifo_pop = 1'b1;
                    cnt_d    = '0;
                    rsp_we_d = head_we;
                    rdata_d  = '0;
                    state_d  = head_we ? StResp : StRdWait;
                end else begin
                    cnt_d = sat_inc(cnt_q);
                    if (cnt_d >= TmoCnt) stall_d = 1'b1;
                end
            end
            StRdWait: begin
                rdata_d = mc_dq;
                state_d = StResp;
            end
            StResp: begin
                state_d = fifo_empty ? StIdle : StReq;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            stall_q  <= 1'b0;
            rsp_we_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            rsp_we_q <= rsp_we_d;
            rdata_q  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Bench for mem_requester: the bench acts as core and memory controller and checks the
// DUT against a queue-based model of accepted commands and expected completions.
module tb_mem_requester;

    localparam int unsigned Tmo = 16;

    typedef struct packed {
        logic       we;
        logic [7:0] addr;
        logic [7:0] data;
    } cmd_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [7:0] cmd_addr = '0, cmd_wdata = '0;
    logic       rsp_valid, rsp_we;
    logic [7:0] rsp_rdata;
    logic       mc_rden, mc_wren, mc_acq = 1'b0;
    logic [7:0] mc_addr, mc_din, mc_dq = '0;
    logic       busy, stall_err;

    always #5 clk = ~clk;

    mem_requester #(
        .ADDR_W (8),
        .DATA_W (8),
        .TMO    (Tmo)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .mc_rden   (mc_rden),
        .mc_wren   (mc_wren),
        .mc_addr   (mc_addr),
        .mc_din    (mc_din),
        .mc_acq    (mc_acq),
        .mc_dq     (mc_dq),
        .busy      (busy),
        .stall_err (stall_err)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    cmd_t       pend_q[$];
    bit         inflight = 1'b0;
    bit         exp_we = 1'b0;
    logic [7:0] exp_rdata = '0;
    int         exp_due = 0;
    int         dq_at = -1;
    int         wait_cnt = 0;
    bit         stall_exp = 1'b0;
    bit         req_seen = 1'b0;
    bit         accepted = 1'b0;
    bit         dq_fixed = 1'b0;
    logic [7:0] dq_val = '0;
    cmd_t       idle_c = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.we   = 1'($urandom);
        c.addr = 8'($urandom);
        c.data = 8'($urandom);
        return c;
    endfunction

    task automatic reset_model();
        pend_q.delete();
        inflight  = 1'b0;
        wait_cnt  = 0;
        stall_exp = 1'b0;
        dq_at     = -1;
    endtask

    // One clock cycle: observe and check at the falling edge, then drive the next inputs.
    task automatic tick(input bit offer, input cmd_t c, input int gpct);
        bit   grant;
        cmd_t h;
        @(negedge clk);
        cyc++;
        req_seen = mc_rden | mc_wren;
        check("cmd_ready", 32'(cmd_ready), 32'(pend_q.size() < 2));
        check("busy", 32'(busy), 32'((pend_q.size() != 0) || inflight));
        check("stall_err", 32'(stall_err), 32'(stall_exp));
        check("req_onehot", 32'(mc_rden & mc_wren), 32'(0));
        if (inflight && cyc == exp_due) begin
            check("rsp_valid", 32'(rsp_valid), 32'(1));
            check("rsp_we", 32'(rsp_we), 32'(exp_we));
            check("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
            inflight = 1'b0;
        end else begin
            check("rsp_quiet", 32'(rsp_valid), 32'(0));
        end
        if (req_seen) begin
            check("req_pending", 32'(pend_q.size() != 0 && !inflight), 32'(1));
            if (pend_q.size() != 0) begin
                h = pend_q[0];
                check("req_we", 32'(mc_wren), 32'(h.we));
                check("req_addr", 32'(mc_addr), 32'(h.addr));
                check("req_din", 32'(mc_din), 32'(h.data));
            end
        end
        // Grants offered while no request is visible must be ignored by the DUT.
        if (req_seen) grant = ($urandom_range(99) < gpct);
        else grant = ($urandom_range(3) == 0);
        if (req_seen && grant && pend_q.size() != 0) begin
            h         = pend_q.pop_front();
            inflight  = 1'b1;
            exp_we    = h.we;
            exp_rdata = '0;
            exp_due   = cyc + (h.we ? 1 : 2);
            dq_at     = h.we ? -1 : cyc + 1;
            wait_cnt  = 0;
        end else if (req_seen) begin
            wait_cnt++;
            if (wait_cnt >= Tmo) stall_exp = 1'b1;
        end
        accepted = offer && cmd_ready;
        if (accepted) pend_q.push_back(c);
        mc_dq = dq_fixed ? dq_val : 8'($urandom);
        if (cyc == dq_at) exp_rdata = mc_dq;
        mc_acq    = grant;
        cmd_valid = offer;
        cmd_we    = c.we;
        cmd_addr  = c.addr;
        cmd_wdata = c.data;
    endtask

    task automatic drive_idle();
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        mc_acq    = 1'b0;
        mc_dq     = '0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        drive_idle();
        reset_model();
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_we", 32'(rsp_we), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_mc_req", 32'({mc_rden, mc_wren}), 32'(0));
        check("rst_mc_addr", 32'(mc_addr), 32'(0));
        check("rst_mc_din", 32'(mc_din), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_stall", 32'(stall_err), 32'(0));
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (pend_q.size() != 0 || inflight); i++) tick(0, idle_c, 100);
        check("drain_done", 32'(pend_q.size() == 0 && !inflight), 32'(1));
        repeat (3) tick(0, idle_c, 100);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cmd_t c;
        int   n;
        apply_reset();

        // Store 0x12/0xA5 held off for two request cycles, granted on the third.
        c = '{we: 1'b1, addr: 8'h12, data: 8'hA5};
        tick(1, c, 0);
        check("st_accept", 32'(accepted), 32'(1));
        n = 0;
        for (int i = 0; i < 20 && n < 2; i++) begin
            tick(0, idle_c, 0);
            if (req_seen) n++;
        end
        tick(0, idle_c, 100);
        check("st_req3_wren", 32'(mc_wren), 32'(1));
        check("st_req3_addr", 32'(mc_addr), 32'(8'h12));
        check("st_req3_din", 32'(mc_din), 32'(8'hA5));
        tick(0, idle_c, 0);
        check("st_rsp_valid", 32'(rsp_valid), 32'(1));
        check("st_rsp_we", 32'(rsp_we), 32'(1));
        check("st_req_dropped", 32'(mc_wren), 32'(0));
        drain();

        // Load 0x40 returning 0x3C: response two cycles after the grant.
        dq_fixed = 1'b1;
        dq_val   = 8'h3C;
        c = '{we: 1'b0, addr: 8'h40, data: 8'h00};
        tick(1, c, 0);
        req_seen = 1'b0;
        for (int i = 0; i < 20 && !req_seen; i++) tick(0, idle_c, 100);
        tick(0, idle_c, 0);
        check("ld_gap", 32'(rsp_valid), 32'(0));
        tick(0, idle_c, 0);
        check("ld_rsp_valid", 32'(rsp_valid), 32'(1));
        check("ld_rsp_rdata", 32'(rsp_rdata), 32'(8'h3C));
        dq_fixed = 1'b0;
        drain();

        // Three back-to-back commands with the grant held off: only two fit.
        tick(1, rand_cmd(), 0);
        tick(1, rand_cmd(), 0);
        c = rand_cmd();
        tick(1, c, 0);
        check("bb_third_blocked", 32'(accepted), 32'(0));
        check("bb_full", 32'(cmd_ready), 32'(0));
        accepted = 1'b0;
        for (int i = 0; i < 50 && !accepted; i++) tick(1, c, 100);
        check("bb_third_accepted", 32'(accepted), 32'(1));
        drain();

        // Randomized traffic.
        for (int i = 0; i < 800; i++) tick($urandom_range(99) < 60, rand_cmd(), 40);
        drain();

        // Grant withheld for 20 request cycles: sticky timeout after 16, request kept.
        apply_reset();
        tick(1, rand_cmd(), 0);
        n = 0;
        for (int i = 0; i < 60 && n < 20; i++) begin
            tick(0, idle_c, 0);
            if (req_seen) begin
                n++;
                if (n == 16) check("stall_before_tmo", 32'(stall_err), 32'(0));
                if (n == 17) check("stall_at_tmo", 32'(stall_err), 32'(1));
            end
        end
        check("stall_req_held", 32'(req_seen), 32'(1));
        drain();
        check("stall_sticky", 32'(stall_err), 32'(1));

        // Reset pulsed while a request is outstanding.
        apply_reset();
        tick(1, rand_cmd(), 0);
        tick(1, rand_cmd(), 0);
        req_seen = 1'b0;
        for (int i = 0; i < 20 && !req_seen; i++) tick(0, idle_c, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_req_drop", 32'({mc_rden, mc_wren}), 32'(0));
        drive_idle();
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick(0, idle_c, 0);
        check("midrst_busy", 32'(busy), 32'(0));
        check("midrst_ready", 32'(cmd_ready), 32'(1));
        tick(0, idle_c, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
